dmem_boot_loader: RTL and testbench
===================================

Name: dmem_boot_loader

Overview:
- Sequences the single-cycle CPU's boot: holds the CPU in reset and streams preload words into data memory through the external write port (Ext_MemWrite / Ext_WriteData / Ext_DataAdr).
- After the stream ends, releases the CPU after a programmable guard delay.
- Sits beside the CPU top and drives its reset and Ext_* inputs; the top accepts external writes only while the CPU reset is high.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of the first preload word (word aligned).
- MAX_WORDS, 64, maximum words per load; count width CW = $clog2(MAX_WORDS+1).
- RELEASE_CYCLES, 4, cycles the CPU stays in reset after the last write (≥1).

Ports:
- clk, in, 1, system clock, rising edge.
- reset, in, 1, asynchronous active-low reset of this block.
- start, in, 1, single-cycle request to begin a load; honoured in IDLE, RUN and ERROR.
- in_valid, in, 1, preload beat valid.
- in_data, in, 32, preload word.
- in_last, in, 1, marks final beat; qualified by in_valid.
- in_ready, out, 1, loader accepts the beat this cycle.
- cpu_reset, out, 1, active-high CPU reset to the top.
- Ext_MemWrite, out, 1, external data-memory write strobe.
- Ext_WriteData, out, 32, external write data.
- Ext_DataAdr, out, 32, external byte address.
- words_loaded, out, CW, words written in the current/last load.
- busy, out, 1, high in LOAD, FLUSH and RELEASE.
- done, out, 1, high in RUN (load complete, CPU running).
- overflow, out, 1, high in ERROR.

Behaviour:
- All outputs are registered except in_ready, which is decoded from state and count.
- Reset (reset=0, async) forces:
  - state IDLE;
  - cpu_reset=1;
  - Ext_MemWrite=0, Ext_WriteData=0, Ext_DataAdr=BASE_ADDR;
  - words_loaded=0, done=0, overflow=0, busy=0.
  - Reset mid-load aborts the load; memory contents already written are left as-is.
- States: IDLE, LOAD, FLUSH, RELEASE, RUN, ERROR.
- IDLE: cpu_reset=1, in_ready=0. On start, go to LOAD and clear words_loaded.
- LOAD: in_ready=1 while words_loaded<MAX_WORDS.
  - Accept = in_valid & in_ready at a rising edge.
  - The cycle after an accept: Ext_MemWrite=1, Ext_WriteData=in_data, Ext_DataAdr=BASE_ADDR+4*k (k = beat index from 0); words_loaded increments at the same edge.
  - Without a new accept, Ext_MemWrite returns to 0 and Ext_DataAdr holds.
  - Back-to-back beats give one write per cycle; throughput is 1 word/clk, latency is 1 clk from accept to strobe.
  - Accept with in_last=1: go to FLUSH.
  - Accept of beat MAX_WORDS with in_last=0: go to ERROR.
  - start is ignored in LOAD.
- FLUSH: the final Ext_MemWrite pulse is issued (cpu_reset still 1). Next state is RELEASE with release counter = RELEASE_CYCLES.
- RELEASE: Ext_MemWrite=0, cpu_reset=1. Counter decrements each cycle; at 0 go to RUN. cpu_reset therefore falls exactly RELEASE_CYCLES+1 cycles after the last write strobe.
- RUN: cpu_reset=0, done=1, words_loaded held.
  - On start: cpu_reset=1 at the next edge and go to LOAD (reload).
- ERROR: cpu_reset=1, overflow=1, in_ready=0. The MAX_WORDS-th write still completes. start restarts the load (LOAD, overflow cleared).
- Address arithmetic is 32-bit modulo 2^32; wrap beyond 32'hFFFF_FFFC is not flagged.
- cpu_reset is never low while Ext_MemWrite=1.

Test Plan:
- Reset: hold reset=0 with random inputs → cpu_reset=1, Ext_MemWrite=0, Ext_DataAdr=0, in_ready=0, done=0.
- Basic load: start; 3 back-to-back beats 0xA, 0xB, 0xC with in_last on the third → strobes on 3 consecutive cycles at addresses 0x0, 0x4, 0x8; words_loaded=3; cpu_reset falls 5 cycles after the 0x8 strobe; done=1.
- Gapped stream: in_valid toggled 1,0,0,1(last) → exactly 2 strobes at 0x0 and 0x4, none during gaps; Ext_DataAdr holds 0x0 during gaps.
- Overflow: MAX_WORDS=4, 4 beats without in_last → 4 writes, in_ready=0 afterwards, overflow=1, cpu_reset stays 1; then start → LOAD, overflow=0, next write at 0x0.
- Reload from RUN: after a completed load, pulse start → cpu_reset=1 next cycle; a 1-beat load writes 0x0; words_loaded=1; done reasserts after release.
- Async reset mid-load: assert reset=0 between beats 2 and 3 of a 5-beat stream → immediate IDLE, Ext_MemWrite=0 without waiting for a clock; no further writes; cpu_reset=1.

Source files
------------

// File: rtl/dmem_boot_loader.sv
// rtl/dmem_boot_loader.sv - holds the CPU in reset while streaming preload words into data memory
module dmem_boot_loader #(
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter int          MAX_WORDS      = 64,
    parameter int          RELEASE_CYCLES = 4,
    localparam int         CW             = $clog2(MAX_WORDS + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          in_valid,
    input  logic [31:0]   in_data,
    input  logic          in_last,
    output logic          in_ready,
    output logic          cpu_reset,
    output logic          Ext_MemWrite,
    output logic [31:0]   Ext_WriteData,
    output logic [31:0]   Ext_DataAdr,
    output logic [CW-1:0] words_loaded,
    output logic          busy,
    output logic          done,
    output logic          overflow
);
    localparam int            RW       = $clog2(RELEASE_CYCLES + 1);
    localparam logic [CW-1:0] MAX_CNT  = CW'(MAX_WORDS);
    localparam logic [RW-1:0] REL_INIT = RW'(RELEASE_CYCLES);
    localparam logic [RW-1:0] REL_ONE  = RW'(1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_FLUSH, S_RELEASE, S_RUN, S_ERROR
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] words_q, words_d;
    logic [RW-1:0] rel_q, rel_d;
    logic          wr_q, wr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   adr_q, adr_d;
    logic          cpu_reset_q, cpu_reset_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          overflow_q, overflow_d;
    logic          accept;

    assign in_ready = (state_q == S_LOAD) && (words_q < MAX_CNT);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        words_d = words_q;
        rel_d   = rel_q;
        wr_d    = 1'b0;
        wdata_d = wdata_q;
        adr_d   = adr_q;
        case (state_q)
            S_IDLE, S_RUN, S_ERROR: begin
                if (start) begin
                    state_d = S_LOAD;
                    words_d = '0;
                end
            end
            S_LOAD: begin
                if (accept) begin
                    wr_d    = 1'b1;
                    wdata_d = in_data;
                    adr_d   = BASE_ADDR + (32'(words_q) << 2);
                    words_d = words_q + CW'(1);
                    // in_last wins over overflow when the final allowed beat is also the last
                    if (in_last)
                        state_d = S_FLUSH;
                    else if (words_d == MAX_CNT)
                        state_d = S_ERROR;
                end
            end
            S_FLUSH: begin
                state_d = S_RELEASE;
                rel_d   = REL_INIT;
            end
            S_RELEASE: begin
                rel_d = rel_q - REL_ONE;
                // leave on the cycle the count would reach zero so release lands RELEASE_CYCLES+1 after the strobe
                if (rel_q == REL_ONE)
                    state_d = S_RUN;
            end
            default: state_d = S_IDLE;
        endcase

        cpu_reset_d = (state_d != S_RUN);
        done_d      = (state_d == S_RUN);
        overflow_d  = (state_d == S_ERROR);
        busy_d      = (state_d == S_LOAD) || (state_d == S_FLUSH) || (state_d == S_RELEASE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            words_q     <= '0;
            rel_q       <= '0;
            wr_q        <= 1'b0;
            wdata_q     <= 32'h0;
            adr_q       <= BASE_ADDR;
            cpu_reset_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            words_q     <= words_d;
            rel_q       <= rel_d;
            wr_q        <= wr_d;
            wdata_q     <= wdata_d;
            adr_q       <= adr_d;
            cpu_reset_q <= cpu_reset_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            overflow_q  <= overflow_d;
        end
    end

    assign cpu_reset     = cpu_reset_q;
    assign Ext_MemWrite  = wr_q;
    assign Ext_WriteData = wdata_q;
    assign Ext_DataAdr   = adr_q;
    assign words_loaded  = words_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign overflow      = overflow_q;

endmodule

// File: tb/tb_dmem_boot_loader.sv
// tb/tb_dmem_boot_loader.sv - directed self-checking bench for dmem_boot_loader
module tb_dmem_boot_loader;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          in_valid;
    logic [31:0]   in_data;
    logic          in_last;
    logic          in_ready;
    logic          cpu_reset;
    logic          Ext_MemWrite;
    logic [31:0]   Ext_WriteData;
    logic [31:0]   Ext_DataAdr;
    logic [CW-1:0] words_loaded;
    logic          busy;
    logic          done;
    logic          overflow;

    int checks = 0;
    int errors = 0;

    dmem_boot_loader #(
        .BASE_ADDR      (32'h0000_0000),
        .MAX_WORDS      (4),
        .RELEASE_CYCLES (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_last       (in_last),
        .in_ready      (in_ready),
        .cpu_reset     (cpu_reset),
        .Ext_MemWrite  (Ext_MemWrite),
        .Ext_WriteData (Ext_WriteData),
        .Ext_DataAdr   (Ext_DataAdr),
        .words_loaded  (words_loaded),
        .busy          (busy),
        .done          (done),
        .overflow      (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [31:0] d, input logic last);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
    endtask

    task automatic idle_in();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic check_write(input string tag, input logic [31:0] adr, input logic [31:0] d);
        check({tag, "_we"},   32'(Ext_MemWrite), 32'd1);
        check({tag, "_adr"},  Ext_DataAdr, adr);
        check({tag, "_data"}, Ext_WriteData, d);
    endtask

    // expects the last strobe at the previous edge; cpu_reset must fall at the 5th edge after it
    task automatic check_release(input string tag);
        for (int i = 1; i <= 5; i++) begin
            tick();
            check({tag, "_we0"}, 32'(Ext_MemWrite), 32'd0);
            check({tag, "_cpurst"}, 32'(cpu_reset), (i < 5) ? 32'd1 : 32'd0);
            check({tag, "_done"}, 32'(done), (i < 5) ? 32'd0 : 32'd1);
        end
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        idle_in();
        in_data = 32'h0;

        // reset with random inputs
        for (int i = 0; i < 4; i++) begin
            start    = 1'($urandom);
            in_valid = 1'($urandom);
            in_last  = 1'($urandom);
            in_data  = $urandom;
            tick();
        end
        check("rst_cpurst", 32'(cpu_reset), 32'd1);
        check("rst_we", 32'(Ext_MemWrite), 32'd0);
        check("rst_adr", Ext_DataAdr, 32'h0);
        check("rst_ready", 32'(in_ready), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        start = 1'b0;
        idle_in();
        reset = 1'b1;
        tick();
        check("idle_ready", 32'(in_ready), 32'd0);

        // basic back-to-back load
        start = 1'b1;
        tick();
        start = 1'b0;
        check("b_busy", 32'(busy), 32'd1);
        check("b_ready", 32'(in_ready), 32'd1);
        beat(32'hA, 1'b0);
        tick();
        check_write("b0", 32'h0, 32'hA);
        beat(32'hB, 1'b0);
        tick();
        check_write("b1", 32'h4, 32'hB);
        beat(32'hC, 1'b1);
        tick();
        check_write("b2", 32'h8, 32'hC);
        check("b_words", 32'(words_loaded), 32'd3);
        idle_in();
        check_release("b_rel");
        check("b_words_run", 32'(words_loaded), 32'd3);
        check("b_busy_run", 32'(busy), 32'd0);

        // gapped stream, entered from RUN
        start = 1'b1;
        tick();
        start = 1'b0;
        check("g_cpurst", 32'(cpu_reset), 32'd1);
        check("g_words0", 32'(words_loaded), 32'd0);
        beat(32'h11, 1'b0);
        tick();
        check_write("g0", 32'h0, 32'h11);
        idle_in();
        for (int i = 0; i < 2; i++) begin
            tick();
            check("g_gap_we", 32'(Ext_MemWrite), 32'd0);
            check("g_gap_adr", Ext_DataAdr, 32'h0);
        end
        beat(32'h22, 1'b1);
        tick();
        check_write("g1", 32'h4, 32'h22);
        check("g_words", 32'(words_loaded), 32'd2);
        idle_in();
        check_release("g_rel");

        // reload from RUN with a single beat
        start = 1'b1;
        tick();
        start = 1'b0;
        check("r_cpurst", 32'(cpu_reset), 32'd1);
        check("r_done", 32'(done), 32'd0);
        beat(32'h33, 1'b1);
        tick();
        check_write("r0", 32'h0, 32'h33);
        check("r_words", 32'(words_loaded), 32'd1);
        idle_in();
        check_release("r_rel");

        // overflow at MAX_WORDS=4
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            beat(32'h100 + 32'(i), 1'b0);
            tick();
            check_write("o", 32'(i) << 2, 32'h100 + 32'(i));
        end
        check("o_ovf", 32'(overflow), 32'd1);
        check("o_ready", 32'(in_ready), 32'd0);
        check("o_words", 32'(words_loaded), 32'd4);
        check("o_cpurst", 32'(cpu_reset), 32'd1);
        tick();
        check("o_we_after", 32'(Ext_MemWrite), 32'd0);
        check("o_ovf_hold", 32'(overflow), 32'd1);
        check("o_ready_hold", 32'(in_ready), 32'd0);
        check("o_busy", 32'(busy), 32'd0);
        idle_in();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("o_restart_ovf", 32'(overflow), 32'd0);
        check("o_restart_ready", 32'(in_ready), 32'd1);
        beat(32'h55, 1'b0);
        tick();
        check_write("o_re0", 32'h0, 32'h55);

        // async reset mid-load: two more beats, then reset between beats 2 and 3
        beat(32'h66, 1'b0);
        tick();
        check_write("a1", 32'h4, 32'h66);
        beat(32'h77, 1'b0);
        #3;
        reset = 1'b0;
        #1;
        check("a_we_async", 32'(Ext_MemWrite), 32'd0);
        check("a_cpurst", 32'(cpu_reset), 32'd1);
        check("a_ready", 32'(in_ready), 32'd0);
        check("a_busy", 32'(busy), 32'd0);
        check("a_adr", Ext_DataAdr, 32'h0);
        tick();
        check("a_we_held", 32'(Ext_MemWrite), 32'd0);
        reset = 1'b1;
        tick();
        check("a_idle_we", 32'(Ext_MemWrite), 32'd0);
        check("a_idle_ready", 32'(in_ready), 32'd0);
        check("a_idle_words", 32'(words_loaded), 32'd0);
        check("a_idle_cpurst", 32'(cpu_reset), 32'd1);
        idle_in();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
